// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
// Ownership states and the width of the burst counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an accelerator cache (port 0) and a host controller (port 1) onto one
// synchronous-RAM port with zero-cycle grants and a per-owner burst limit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_do
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    arb_state_t             state, state_next;
    logic                   last_owner;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   burst_done;
    logic                   pick0, pick1;
    logic                   rvalid0_p1, rvalid1_p1;

    function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] cnt);
        return (cnt >= BURST_LIMIT) ? BURST_LIMIT : cnt + 1'b1;
    endfunction

    assign burst_done = (burst_cnt >= BURST_LIMIT);

    // The owner yields only once its burst is spent and the other side is waiting.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        unique case (state)
            OWN0: begin
                if (req0 && !(burst_done && req1)) pick0 = 1'b1;
                else if (req1)                     pick1 = 1'b1;
            end
            OWN1: begin
                if (req1 && !(burst_done && req0)) pick1 = 1'b1;
                else if (req0)                     pick0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    pick0 = last_owner;
                    pick1 = !last_owner;
                end else begin
                    pick0 = req0;
                    pick1 = req1;
                end
            end
        endcase
    end

    assign gnt0 = pick0 && !rst;
    assign gnt1 = pick1 && !rst;

    always_comb begin
        state_next = IDLE;
        if (gnt0)      state_next = OWN0;
        else if (gnt1) state_next = OWN1;
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        if (gnt0) begin
            mem_en   = 1'b1;
            mem_we   = we0;
            mem_addr = addr0;
            mem_di   = wdata0;
        end else if (gnt1) begin
            mem_en   = 1'b1;
            mem_we   = we1;
            mem_addr = addr1;
            mem_di   = wdata1;
        end
    end

    // Stage p1: read data returns from the RAM one cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            rvalid0_p1 <= 1'b0;
            rvalid1_p1 <= 1'b0;
        end else begin
            state      <= state_next;
            rvalid0_p1 <= gnt0 && !we0;
            rvalid1_p1 <= gnt1 && !we1;
            if (gnt0 || gnt1) last_owner <= gnt1;
            // The new owner's first granted cycle already counts toward its burst.
            if (!(gnt0 || gnt1))
                burst_cnt <= '0;
            else if ((gnt0 && state == OWN0) || (gnt1 && state == OWN1))
                burst_cnt <= sat_inc(burst_cnt);
            else
                burst_cnt <= BURST_CNT_W'(1);
        end
    end

    assign rvalid0 = rvalid0_p1;
    assign rvalid1 = rvalid1_p1;
    assign rdata0  = mem_do;
    assign rdata1  = mem_do;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural arbitration model
// and a 1-cycle-latency RAM attached to the memory port.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MB    = 8;
    localparam int RAM_N = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_di;
    logic [DW-1:0] mem_do = '0;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do)
    );

    // Environment RAM seen by the DUT.
    logic [DW-1:0] ram [RAM_N];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[8:0]] <= mem_di;
            else        mem_do <= ram[mem_addr[8:0]];
        end
    end

    typedef struct {
        logic          g0, g1, en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
    } bus_t;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    bus_t          exp_q[$];
    rd_t           rd_q[$];
    logic [DW-1:0] ref_mem [RAM_N];
    int            owner = -1;   // requester granted last cycle, -1 if none
    int            run   = 0;    // consecutive grants to that requester
    int            last  = 1;    // most recently served requester
    int            cyc   = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arbitration: decide who is served this cycle from the request history.
    task automatic model_step();
        bit   want [2];
        int   g;
        int   other;
        bus_t e;
        want[0] = req0;
        want[1] = req1;
        g = -1;
        if (!rst) begin
            if (owner < 0) begin
                if (want[0] && want[1]) g = 1 - last;
                else if (want[0])       g = 0;
                else if (want[1])       g = 1;
            end else begin
                other = 1 - owner;
                if (want[owner] && !(run >= MB && want[other])) g = owner;
                else if (want[other])                            g = other;
            end
        end
        e = '{1'b0, 1'b0, 1'b0, 1'b0, '0, '0};
        if (g == 0) e = '{1'b1, 1'b0, 1'b1, we0, addr0, wdata0};
        if (g == 1) e = '{1'b0, 1'b1, 1'b1, we1, addr1, wdata1};
        exp_q.push_back(e);
        if (g >= 0) begin
            if (e.we) ref_mem[e.addr[8:0]] = e.di;
            else      rd_q.push_back('{g, ref_mem[e.addr[8:0]], cyc + 1});
            run   = (g == owner) ? ((run < MB) ? run + 1 : MB) : 1;
            owner = g;
            last  = g;
        end else begin
            owner = -1;
            run   = 0;
        end
        if (rst) begin
            owner = -1;
            run   = 0;
            last  = 1;
        end
    endtask

    task automatic drive(input logic r, input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        if (r) rd_q.delete();
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        model_step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_cycle(input int p_req);
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom_range(0, 31));
        a1 = AW'($urandom_range(0, 31));
        drive(1'b0, $urandom_range(0, 99) < p_req, 1'($urandom), a0, $urandom,
                    $urandom_range(0, 99) < p_req, 1'($urandom), a1, $urandom);
    endtask

    // Monitor: compare the memory-side bundle and the read-return stream each cycle.
    always @(negedge clk) begin
        bus_t e;
        rd_t  rr;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_di} !== {e.g0, e.g1, e.en, e.we, e.addr, e.di}) begin
                n_fail++;
                $display("FAIL bus cyc=%0d got g0=%b g1=%b en=%b we=%b addr=%h di=%h want g0=%b g1=%b en=%b we=%b addr=%h di=%h",
                         cyc, gnt0, gnt1, mem_en, mem_we, mem_addr, mem_di, e.g0, e.g1, e.en, e.we, e.addr, e.di);
            end
            n_chk++;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                rr = rd_q.pop_front();
                if (rvalid0 !== (rr.who == 0) || rvalid1 !== (rr.who == 1) ||
                    ((rr.who == 0) ? rdata0 : rdata1) !== rr.data) begin
                    n_fail++;
                    $display("FAIL rdata cyc=%0d got rv0=%b rv1=%b rd0=%h rd1=%h want port%0d data=%h",
                             cyc, rvalid0, rvalid1, rdata0, rdata1, rr.who, rr.data);
                end
            end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rvalid cyc=%0d got rv0=%b rv1=%b want none", cyc, rvalid0, rvalid1);
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < RAM_N; i++) begin
            v = DW'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[16]     = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;

        // Reset with random request activity: everything must stay quiet.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 31)), $urandom,
                        1'($urandom), 1'($urandom), AW'($urandom_range(0, 31)), $urandom);

        // Simultaneous requests straight after reset, then requester 0 drops.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 8), '0);
        for (int i = 0; i < 2; i++)
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i + 20), '0);
        idle();

        // Single read of a known word.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Host writes, accelerator reads it back.
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0100, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b0, 16'h0100, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Both held continuously: burst alternation.
        for (int i = 0; i < 40; i++)
            drive(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 31)), '0,
                        1'b1, 1'b0, AW'($urandom_range(0, 31)), '0);
        idle();

        for (int i = 0; i < 300; i++) rand_cycle(75);
        for (int i = 0; i < 300; i++) rand_cycle(40);
        idle();

        // Reset lands one cycle after a granted read.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 16'h0011, '0, 1'b1, 1'b0, 16'h0012, '0);
        drive(1'b1, 1'b1, 1'b1, 16'h0011, 32'hFFFF_FFFF, 1'b1, 1'b1, 16'h0012, 32'hFFFF_FFFF);
        idle();
        @(negedge clk);
        n_chk++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL state_after_reset got %0d want %0d", dut.state, IDLE);
        end
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 4), '0);
        idle();
        idle();

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got bus=%0d reads=%0d pending want 0", exp_q.size(), rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive granted cycles per owner while the other requester waits; legal range 1-255.
REQ-004 SHALL have ports: clk input 1, clock; rst input 1, reset (asynchronous, active-high).
REQ-005 SHALL have ports req0/req1 input 1, access request from requester 0 (accelerator cache) / 1 (host controller).
REQ-006 SHALL have ports we0/we1 input 1, write enable; addr0/addr1 input ADDR_WIDTH, word address; wdata0/wdata1 input DATA_WIDTH, write data.
REQ-007 SHALL have ports gnt0/gnt1 output 1, access issued this cycle.
REQ-008 SHALL have ports rvalid0/rvalid1 output 1, read data valid; rdata0/rdata1 output DATA_WIDTH, read data.
REQ-009 SHALL have ports mem_en, mem_we output 1; mem_addr output ADDR_WIDTH; mem_di output DATA_WIDTH; mem_do input DATA_WIDTH; single synchronous-RAM port, 1-cycle read latency.

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1, held in a register; owner = state.
REQ-011 SHALL, in IDLE, grant req0 when only req0 is high, req1 when only req1 is high, and on simultaneous requests grant the requester not served last (last_owner register, reset value 1, so requester 0 wins first tie).
REQ-012 SHALL decide grants combinationally from current req and registered state: the granted request is issued to memory in the same cycle (zero-cycle grant latency).
REQ-013 SHALL assert at most one of gnt0/gnt1 per cycle; gntN high only when reqN high.
REQ-014 SHALL drive mem_en=1, mem_we=weN, mem_addr=addrN, mem_di=wdataN of the granted requester; mem_en=0, mem_we=0, other memory outputs don't-care (drive 0) when no grant.
REQ-015 SHALL hold ownership (OWNn) while reqN stays high, counting granted cycles in burst_cnt (8 bits, cleared on ownership change).
REQ-016 SHALL switch ownership to the other requester in the cycle after burst_cnt reaches MAX_BURST if the other req is high; otherwise ownership continues and burst_cnt saturates at MAX_BURST.
REQ-017 SHALL, when the owner drops req, grant the other requester in that same cycle if its req is high (transition OWNn -> OWNm), else return to IDLE.
REQ-018 SHALL pulse rvalidN exactly one cycle after a granted read (gntN=1, weN=0), with rdataN = mem_do during that cycle; no rvalid for writes.
REQ-019 SHALL route mem_do to both rdata outputs; only the rvalid qualifies it.
REQ-020 SHALL keep back-to-back reads pipelined: one grant per cycle, rvalid stream delayed by exactly one cycle.
REQ-021 SHALL not require requesters to deassert req between accesses; a requester presents the next access in the cycle after gnt.

Reset
REQ-022 SHALL, on rst, force state=IDLE, last_owner=1, burst_cnt=0, rvalid pipeline registers=0 asynchronously.
REQ-023 SHALL hold gnt0=gnt1=0, rvalid0=rvalid1=0, mem_en=0, mem_we=0 while rst is high, regardless of req.
REQ-024 SHALL discard any in-flight read when rst asserts mid-operation (no rvalid after reset release).

Structure
REQ-025 SHALL place the state enum type (IDLE, OWN0, OWN1) in shared package mem_arb_pkg.
REQ-026 SHALL be a single module with no sub-modules; sits between cache/controller and memory3 port A in top, replacing the direct controller port-B connection.

Verification
REQ-027 SHALL verify: req0 alone, read addr 0x0010, mem holds 0xDEADBEEF -> gnt0 same cycle, rvalid0=1 with rdata0=0xDEADBEEF next cycle.
REQ-028 SHALL verify: req0 and req1 both rise first cycle after reset -> gnt0 first; after req0 drops, gnt1 in that cycle.
REQ-029 SHALL verify: req0 held continuously, req1 high, MAX_BURST=8 -> exactly 8 gnt0 cycles, then gnt1, then alternation per burst limit.
REQ-030 SHALL verify: req1 writes 0x12345678 to 0x0100, then req0 reads 0x0100 -> rdata0=0x12345678, rvalid1 never asserted.
REQ-031 SHALL verify: rst asserted one cycle after granted read -> no rvalid, all outputs 0 during reset, state IDLE after release.
